// File: rtl/ram_fifo_pkg.sv
// Shared sizing and helpers for the RAM-backed FIFO controller and its output buffer.
package ram_fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_AW    = 7;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int FIFO_LVLW  = FIFO_AW + 2;

  // True when a word issued now still has a buffer slot waiting for it next cycle.
  function automatic logic rd_room(input logic [1:0] buf_cnt, input logic rd_pend, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    return (occ < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer that absorbs the one-cycle RAM read latency.
// head drives the consumer; skid holds the word that arrived while head was busy.
module fifo_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          head_valid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] head_q, head_d, skid_q, skid_d;
  logic          head_v_q, head_v_d, skid_v_q, skid_v_d;

  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    case ({push_i, pop_i})
      2'b01: begin
        if (skid_v_q) begin
          head_d   = skid_q;
          skid_v_d = 1'b0;
        end else begin
          head_v_d = 1'b0;
        end
      end
      2'b10: begin
        if (!head_v_q) begin
          head_d   = data_i;
          head_v_d = 1'b1;
        end else begin
          skid_d   = data_i;
          skid_v_d = 1'b1;
        end
      end
      2'b11: begin
        // Older skid word advances first so order stays strictly FIFO.
        if (skid_v_q) begin
          head_d = skid_q;
          skid_d = data_i;
        end else begin
          head_d   = data_i;
          head_v_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush_i) begin
      head_q   <= {DW{1'b0}};
      head_v_q <= 1'b0;
      skid_q   <= {DW{1'b0}};
      skid_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign head_data_o  = head_q;
  assign head_valid_o = head_v_q;
  assign count_o      = {1'b0, head_v_q} + {1'b0, skid_v_q};

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Ready/valid FIFO controller in front of a 2^AW x DW dual-port RAM with registered read.
// Port 1 writes, port 2 reads; fifo_skid_buf hides the read latency.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW+1:0] level,
  output logic [AW-1:0] ram_a1,
  output logic [DW-1:0] ram_d1,
  output logic          ram_we1,
  output logic [AW-1:0] ram_a2,
  output logic          ram_we2,
  input  logic [DW-1:0] ram_q2
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW+1:0] level_q, level_d;

  logic          flush_s;
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          rd_issue_s;
  logic [1:0]    buf_cnt_s;

  // Fullness is judged on registered state only, so a same-cycle pop never frees room.
  always_comb begin
    flush_s    = rst | clr;
    in_ready_s = ~rst & (ram_cnt_q != FULL_CNT);
    push_s     = in_valid & in_ready_s;
    pop_s      = out_valid & out_ready;
    rd_issue_s = (ram_cnt_q != {(AW+1){1'b0}}) & rd_room(buf_cnt_s, rd_pend_q, pop_s);
    wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, push_s};
    rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, rd_issue_s};
    ram_cnt_d  = ram_cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, rd_issue_s};
    rd_pend_d  = rd_issue_s;
    level_d    = level_q + {{(AW+1){1'b0}}, push_s} - {{(AW+1){1'b0}}, pop_s};
  end

  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      ram_cnt_q <= {(AW+1){1'b0}};
      rd_pend_q <= 1'b0;
      level_q   <= {(AW+2){1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      level_q   <= level_d;
    end
  end

  // Flushing the buffer together with rd_pend drops any read still in flight.
  fifo_skid_buf #(
    .DW (DW)
  ) u_buf (
    .clk          (clk),
    .flush_i      (flush_s),
    .push_i       (rd_pend_q),
    .data_i       (ram_q2),
    .pop_i        (pop_s),
    .head_data_o  (out_data),
    .head_valid_o (out_valid),
    .count_o      (buf_cnt_s)
  );

  assign in_ready = in_ready_s;
  assign ram_we1  = push_s;
  assign ram_a1   = wr_ptr_q;
  assign ram_d1   = in_data;
  assign ram_a2   = rd_ptr_q;
  assign ram_we2  = 1'b0;
  assign level    = level_q;

endmodule
